// File: rtl/reg_write_arbiter.sv
// Register file write-port arbiter: clears x0..x31 after reset, then
// arbitrates writeback (A) against a long-latency unit (B) with a starvation guard.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   a_valid_i/a_addr_i/a_data_i    requester A (pipeline writeback)
//   a_ready_o                      A accepted when a_valid_i && a_ready_o
//   b_valid_i/b_addr_i/b_data_i    requester B (long-latency unit)
//   b_ready_o                      B accepted when b_valid_i && b_ready_o
//   RDaddr_o/RDdata_o/RegWrite_o   register file write port
//   init_busy_o                    high while the clear sequence runs
module reg_write_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        a_valid_i,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [4:0]  b_addr_i,
    input  logic [31:0] b_data_i,
    output logic        b_ready_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        RegWrite_o,
    output logic        init_busy_o
);

    localparam logic [2:0] MAX_W = 3'(MAX_WAIT);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  init_cnt_q, init_cnt_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;

    logic        b_prio;
    logic        a_gnt;
    logic        b_gnt;

    // B takes priority once it has been denied MAX_WAIT cycles in a row.
    assign b_prio = (state_q == S_RUN) && (wait_cnt_q >= MAX_W);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_INIT;
            init_cnt_q <= 5'd0;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = 3'd0;
        unique case (state_q)
            S_INIT: begin
                // Wraps back to 0 on the final clear write.
                init_cnt_d = init_cnt_q + 5'd1;
                if (init_cnt_q == 5'd31) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (b_valid_i && !b_gnt) begin
                    if (wait_cnt_q >= MAX_W) begin
                        wait_cnt_d = wait_cnt_q;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Outputs are gated by rst_n_i so reset forces them without a clock edge.
    always_comb begin
        a_ready_o   = 1'b0;
        b_ready_o   = 1'b0;
        init_busy_o = 1'b1;
        RegWrite_o  = 1'b0;
        RDaddr_o    = 5'd0;
        RDdata_o    = 32'd0;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        if (rst_n_i) begin
            unique case (state_q)
                S_INIT: begin
                    RegWrite_o = 1'b1;
                    RDaddr_o   = init_cnt_q;
                end
                S_RUN: begin
                    init_busy_o = 1'b0;
                    if (b_prio) begin
                        b_ready_o = 1'b1;
                        a_ready_o = !b_valid_i;
                    end else begin
                        a_ready_o = 1'b1;
                        b_ready_o = !a_valid_i;
                    end
                    a_gnt = a_valid_i && a_ready_o;
                    b_gnt = b_valid_i && b_ready_o;
                    if (a_gnt) begin
                        RDaddr_o = a_addr_i;
                        RDdata_o = a_data_i;
                    end else if (b_gnt) begin
                        RDaddr_o = b_addr_i;
                        RDdata_o = b_data_i;
                    end
                    // x0 is hardwired zero: handshake completes, no write.
                    RegWrite_o = (a_gnt || b_gnt) && (RDaddr_o != 5'd0);
                end
                default: begin
                    init_busy_o = 1'b1;
                end
            endcase
        end
    end

endmodule
